alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle 32-bit ALU. Widens the datapath and operation set (shifts, comparisons) and adds a two-stage pipeline with valid/ready handshakes on both sides, so it can sit between an operand-issue stage and a writeback/result queue. Full throughput is one operation per cycle. A tag travels with each operation so downstream logic can match results to requests.

---
 rtl/alu_pipe.sv | 162 ++++++++++++++++
 tb/tb_alu_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and a request tag.
// Define ALU_PIPE_FLAGS_EN to add the {ovf, carry, neg, zero} flags port and its registers.
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opsel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_PIPE_FLAGS_EN
    ,
    output logic [3:0]       flags
`endif
);

    localparam int SH_W = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    logic             r_s1_valid;
    logic [3:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_s2_load;
    logic             w_in_fire;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [SH_W-1:0]  w_shamt;
    logic             w_eq;
    logic             w_lt;

    // S1 advances into S2 whenever S2 is empty or draining this cycle; no skid buffer
    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_in_fire = in_valid && in_ready;

    assign w_shamt = r_s1_b[SH_W-1:0];
    assign w_eq    = (r_s1_a == r_s1_b);
    assign w_lt    = ($signed(r_s1_a) < $signed(r_s1_b));

`ifdef ALU_PIPE_FLAGS_EN
    logic       w_add_c;
    logic       w_sub_borrow;
    logic       w_carry;
    logic       w_ovf;
    logic [3:0] w_flags;
    logic [3:0] r_flags;

    assign {w_add_c, w_add}      = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign {w_sub_borrow, w_sub} = {1'b0, r_s1_a} - {1'b0, r_s1_b};

    // Carry/overflow are only meaningful for ADD and SUB
    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_s1_op)
            4'd0: begin
                w_carry = w_add_c;
                w_ovf   = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_add[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            4'd1: begin
                w_carry = ~w_sub_borrow;
                w_ovf   = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_s1_a[WIDTH-1]);
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    assign w_flags = {w_ovf, w_carry, w_result[WIDTH-1], (w_result == {WIDTH{1'b0}})};
    assign flags   = r_flags;
`else
    assign w_add = r_s1_a + r_s1_b;
    assign w_sub = r_s1_a - r_s1_b;
`endif

    // Result mux for the operation held in S1
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (r_s1_op)
            4'd0:    w_result = w_add;
            4'd1:    w_result = w_sub;
            4'd2:    w_result = r_s1_a & r_s1_b;
            4'd3:    w_result = r_s1_a | r_s1_b;
            4'd4:    w_result = r_s1_a ^ r_s1_b;
            4'd5:    w_result = ~(r_s1_a & r_s1_b);
            4'd6:    w_result = ~(r_s1_a | r_s1_b);
            4'd7:    w_result = ~(r_s1_a ^ r_s1_b);
            4'd8:    w_result = {r_s1_b[HALF-1:0], {HALF{1'b0}}};
            4'd9:    w_result = r_s1_a << w_shamt;
            4'd10:   w_result = r_s1_a >> w_shamt;
            4'd11:   w_result = $unsigned($signed(r_s1_a) >>> w_shamt);
            4'd12:   w_result = {{(WIDTH-1){1'b0}}, w_eq};
            4'd13:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
            4'd14:   w_result = {{(WIDTH-1){1'b0}}, (w_lt || w_eq)};
            4'd15:   w_result = {{(WIDTH-1){1'b0}}, ~w_eq};
            default: w_result = {WIDTH{1'b0}};
        endcase
    end

    // Stage 1: operand capture on input transfer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 4'd0;
            r_s1_a     <= {WIDTH{1'b0}};
            r_s1_b     <= {WIDTH{1'b0}};
            r_s1_tag   <= {TAG_W{1'b0}};
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= opsel;
            r_s1_a     <= A;
            r_s1_b     <= B;
            r_s1_tag   <= in_tag;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register, held while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_out      <= {WIDTH{1'b0}};
            r_out_tag  <= {TAG_W{1'b0}};
`ifdef ALU_PIPE_FLAGS_EN
            r_flags    <= 4'd0;
`endif
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_out      <= w_result;
            r_out_tag  <= r_s1_tag;
`ifdef ALU_PIPE_FLAGS_EN
            r_flags    <= w_flags;
`endif
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32); expected results come from an
// arithmetic reference model and are matched in order against the output handshake.
`timescale 1ns/1ps
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opsel = 4'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [3:0]  in_tag = 4'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [3:0]  out_tag;
`ifdef ALU_PIPE_FLAGS_EN
    logic [3:0]  flags;
`endif

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   chk_lat = 1'b0;
    bit   done = 1'b0;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opsel(opsel), .A(A), .B(B), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_tag(out_tag)
`ifdef ALU_PIPE_FLAGS_EN
        , .flags(flags)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a & b);
            4'd6:  return ~(a | b);
            4'd7:  return ~(a ^ b);
            4'd8:  return (b % 32'd65536) * 32'd65536;
            4'd9:  return a << sh;
            4'd10: return a >> sh;
            4'd11: return $unsigned($signed(a) >>> sh);
            4'd12: return (a == b) ? 32'd1 : 32'd0;
            4'd13: return ($signed(a) <  $signed(b)) ? 32'd1 : 32'd0;
            4'd14: return ($signed(a) <= $signed(b)) ? 32'd1 : 32'd0;
            default: return (a != b) ? 32'd1 : 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] ref_flg(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r = ref_res(op, a, b);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic c = 1'b0;
        logic v = 1'b0;
        if (op == 4'd0) begin
            c = (ua + ub) >= 64'sd4294967296;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 4'd1) begin
            c = (a >= b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {v, c, r[31], (r == 32'd0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record the expected response of every accepted request
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready)
            exp_q.push_back('{tag: in_tag, res: ref_res(opsel, A, B), flg: ref_flg(opsel, A, B), acc: cyc});
    end

    // Monitor: compare the presented result with the oldest expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got tag %0d data 0x%08h, expected no output", out_tag, out);
            end else begin
                check("out", out, exp_q[0].res);
                check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
`ifdef ALU_PIPE_FLAGS_EN
                check("flags", 32'(flags), 32'(exp_q[0].flg));
`endif
                if (out_ready) begin
                    if (chk_lat) check("latency", 32'(cyc - exp_q[0].acc), 32'd2);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic set_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        opsel = op; A = a; B = b; in_tag = tag; in_valid = 1'b1;
    endtask

    task automatic wait_acc();
        int k = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected acceptance");
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        set_req(op, a, b, tag);
        wait_acc();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int k;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
`ifdef ALU_PIPE_FLAGS_EN
        check("rst_flags", 32'(flags), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back logic/arith ops with exact latency
        out_ready = 1'b1;
        chk_lat = 1'b1;
        issue(4'd0, 32'd20, 32'd17, 4'd1);
        issue(4'd1, 32'd20, 32'd17, 4'd2);
        issue(4'd3, 32'd20, 32'd17, 4'd3);
        issue(4'd4, 32'd20, 32'd17, 4'd4);
        issue(4'd5, 32'd20, 32'd17, 4'd5);
        issue(4'd6, 32'd20, 32'd17, 4'd6);
        issue(4'd7, 32'd20, 32'd17, 4'd7);
        issue(4'd8, 32'd0, 32'h00001234, 4'd8);
        issue(4'd11, 32'h80000000, 32'd4, 4'd9);
        issue(4'd10, 32'h80000000, 32'd4, 4'd10);
        issue(4'd13, 32'hFFFFFFFF, 32'd1, 4'd11);
        issue(4'd0, 32'h7FFFFFFF, 32'd1, 4'd12);
        issue(4'd1, 32'd5, 32'd5, 4'd13);
        idle(4);
        chk_lat = 1'b0;

        // Stall: two accepted, third blocked until the consumer is ready
        out_ready = 1'b0;
        issue(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 4'd1);
        issue(4'd9, 32'h00000001, 32'd31, 4'd2);
        set_req(4'd14, 32'd7, 32'd7, 4'd3);
        repeat (3) begin
            @(negedge clk);
            check("in_ready_full", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_acc();
        idle(4);

        // Reset with two operations in flight
        issue(4'd0, 32'd1, 32'd2, 4'd5);
        issue(4'd0, 32'd3, 32'd4, 4'd6);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_out", out, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        idle(5);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Random traffic with random back-pressure
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    ra = $urandom;
                    k = $urandom_range(0, 3);
                    rb = (k == 0) ? ra : ((k == 1) ? 32'($urandom_range(0, 40)) : $urandom);
                    issue(4'($urandom_range(0, 15)), ra, rb, 4'(i));
                    if ($urandom_range(0, 7) == 0) idle(1);
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join

        out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(3);
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
